// File: rtl/cla_subtractor_seq.sv
// Multi-cycle WIDTH-bit subtractor: one borrow-look-ahead nibble per clock, LSB nibble first.
// Optional macro SUB_SAT_EN: clamp the difference to zero on underflow (bout still reports 1).
module cla_subtractor_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dina,
    input  logic [WIDTH-1:0] dinb,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             bout
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_dout;
    logic             r_borrow;
    logic             r_bout;
    logic [IDX_W-1:0] r_idx;
    logic [4:0]       w_nib;

    // Returns {borrow_out, diff[3:0]}; every borrow is expanded from g/p so no ripple path exists.
    function automatic logic [4:0] nib_sub(input logic [3:0] a, input logic [3:0] b,
                                           input logic bi);
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] d;
        logic [4:0] br;
        d     = a ^ b;
        g     = ~a & b;
        p     = ~(a ^ b);
        br[0] = bi;
        br[1] = g[0] | (p[0] & bi);
        br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
        br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
        br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bi);
        return {br[4], d ^ br[3:0]};
    endfunction

    assign w_nib = nib_sub(r_a[{r_idx, 2'b00} +: 4], r_b[{r_idx, 2'b00} +: 4], r_borrow);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)       w_next = CALC;
            CALC:    if (r_idx == LAST)  w_next = DONE;
            DONE:    if (out_ready)      w_next = IDLE;
            default:                     w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_dout   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= dina;
                        r_b      <= dinb;
                        r_borrow <= bin;
                        r_idx    <= '0;
                    end
                end
                CALC: begin
                    r_dout[{r_idx, 2'b00} +: 4] <= w_nib[3:0];
                    r_borrow                    <= w_nib[4];
                    r_idx                       <= r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_bout <= w_nib[4];
                        r_idx  <= '0;
`ifdef SUB_SAT_EN
                        // Later assignment overrides the final nibble write on underflow.
                        if (w_nib[4]) r_dout <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout = r_dout;
    assign bout = r_bout;

endmodule
